// File: rtl/seven_seg_reader.sv
// Reads a seven-segment display pattern: debounces it, decodes the digit and
// detects a display blinking between a reference pattern and blank.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MIN_PHASE     = 16,
  parameter int unsigned MAX_PHASE     = 8388606
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  output logic [3:0]  code,
  output logic        blinking,
  output logic        illegal,
  output logic [22:0] half_period,
  output logic        upd
);

  localparam logic [2:0] ST_EMPTY     = 3'd0;
  localparam logic [2:0] ST_STEADY    = 3'd1;
  localparam logic [2:0] ST_GAP       = 3'd2;
  localparam logic [2:0] ST_BLINK_ON  = 3'd3;
  localparam logic [2:0] ST_BLINK_OFF = 3'd4;

  localparam logic [22:0] PH_SAT = '1;
  localparam logic [22:0] MIN_L  = 23'(MIN_PHASE);
  localparam logic [22:0] MAX_L  = 23'(MAX_PHASE);
  localparam logic [3:0]  STAB_N = 4'(STABLE_CYCLES);
  localparam logic [6:0]  BLANK  = 7'h00;

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'h7E:   decode = 4'd0;
      7'h30:   decode = 4'd1;
      7'h6D:   decode = 4'd2;
      7'h79:   decode = 4'd3;
      7'h33:   decode = 4'd4;
      7'h5B:   decode = 4'd5;
      7'h5F:   decode = 4'd6;
      7'h70:   decode = 4'd7;
      7'h7F:   decode = 4'd8;
      7'h7B:   decode = 4'd9;
      7'h00:   decode = 4'd10;
      7'h01:   decode = 4'd11;
      7'h77:   decode = 4'd12;
      7'h67:   decode = 4'd13;
      default: decode = 4'd15;
    endcase
  endfunction

  function automatic logic in_range(input logic [22:0] len);
    return (len >= MIN_L) && (len <= MAX_L);
  endfunction

  logic [6:0]  seg_q, cand_q, cand_d, acc_q, acc_d, ref_q, ref_d;
  logic [3:0]  stab_q, stab_d;
  logic [22:0] phase_q, phase_d, onlen_q, onlen_d, half_q, half_d;
  logic [2:0]  state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic        blink_q, blink_d, illegal_q, illegal_d, upd_q, upd_d;
  logic        accept, is_blank, is_ref, len_ok, timeout;

  // A candidate is accepted once it has been seen for STABLE_CYCLES cycles,
  // exactly once, and only if it differs from the previously accepted value.
  assign accept   = (stab_q == STAB_N) && (cand_q != acc_q);
  assign is_blank = (cand_q == BLANK);
  assign is_ref   = (cand_q == ref_q);
  assign len_ok   = in_range(phase_q);
  assign timeout  = (phase_q > MAX_L);

  always_comb begin
    cand_d = seg_q;
    if (seg_q != cand_q)       stab_d = 4'd1;
    else if (stab_q == STAB_N) stab_d = stab_q;
    else                       stab_d = stab_q + 4'd1;
    acc_d = accept ? cand_q : acc_q;
    if (accept)                phase_d = 23'd1;
    else if (phase_q == PH_SAT) phase_d = phase_q;
    else                       phase_d = phase_q + 23'd1;
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    onlen_d = onlen_q;
    half_d  = half_q;
    blink_d = blink_q;
    case (state_q)
      ST_EMPTY: if (accept && !is_blank) begin
        ref_d   = cand_q;
        state_d = ST_STEADY;
      end
      ST_STEADY: if (accept) begin
        if (is_blank) begin
          onlen_d = phase_q;
          state_d = ST_GAP;
        end else begin
          ref_d = cand_q;
        end
      end
      ST_GAP: begin
        if (accept && is_ref) begin
          if (in_range(onlen_q) && len_ok) begin
            state_d = ST_BLINK_ON;
            blink_d = 1'b1;
            half_d  = phase_q;
          end else begin
            state_d = ST_STEADY;
          end
        end else if (accept && !is_blank) begin
          ref_d   = cand_q;
          state_d = ST_STEADY;
        end else if (!accept && timeout) begin
          state_d = ST_EMPTY;
        end
      end
      ST_BLINK_ON: begin
        if (accept && is_blank) begin
          onlen_d = phase_q;
          if (len_ok) begin
            state_d = ST_BLINK_OFF;
            half_d  = phase_q;
          end else begin
            state_d = ST_GAP;
            blink_d = 1'b0;
          end
        end else if (accept) begin
          ref_d   = cand_q;
          state_d = ST_STEADY;
          blink_d = 1'b0;
        end else if (timeout) begin
          state_d = ST_STEADY;
          blink_d = 1'b0;
        end
      end
      ST_BLINK_OFF: begin
        if (accept && is_ref) begin
          if (len_ok) begin
            state_d = ST_BLINK_ON;
            half_d  = phase_q;
          end else begin
            state_d = ST_STEADY;
            blink_d = 1'b0;
          end
        end else if (accept && !is_blank) begin
          ref_d   = cand_q;
          state_d = ST_STEADY;
          blink_d = 1'b0;
        end else if (!accept && timeout) begin
          state_d = ST_EMPTY;
          blink_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        blink_d = 1'b0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the accepting edge.
  always_comb begin
    code_d    = (state_d == ST_EMPTY) ? 4'd10 : decode(ref_d);
    illegal_d = (state_d != ST_EMPTY) && (decode(ref_d) == 4'd15);
    upd_d     = (code_d != code_q) || (blink_d != blink_q) || (illegal_d != illegal_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      acc_q     <= '0;
      ref_q     <= '0;
      phase_q   <= '0;
      onlen_q   <= '0;
      half_q    <= '0;
      state_q   <= ST_EMPTY;
      code_q    <= 4'd10;
      blink_q   <= 1'b0;
      illegal_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      seg_q     <= seg;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      acc_q     <= acc_d;
      ref_q     <= ref_d;
      phase_q   <= phase_d;
      onlen_q   <= onlen_d;
      half_q    <= half_d;
      state_q   <= state_d;
      code_q    <= code_d;
      blink_q   <= blink_d;
      illegal_q <= illegal_d;
      upd_q     <= upd_d;
    end
  end

  assign code        = code_q;
  assign blinking    = blink_q;
  assign illegal     = illegal_q;
  assign half_period = half_q;
  assign upd         = upd_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed and randomized checks of seven_seg_reader against a pattern-history
// reference model of the reader behaviour.
module tb_seven_seg_reader;

  localparam int SC   = 4;
  localparam int MINP = 8;
  localparam int MAXP = 100;
  localparam int SAT  = 8388607;

  localparam int M_EMPTY = 0, M_STEADY = 1, M_GAP = 2, M_BON = 3, M_BOFF = 4;

  localparam logic [6:0] TBL [14] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                      7'h70, 7'h7F, 7'h7B, 7'h00, 7'h01, 7'h77, 7'h67};
  localparam logic [6:0] BAD [3]  = '{7'h4A, 7'h12, 7'h1C};

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  code;
  logic        blinking, illegal, upd;
  logic [22:0] half_period;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_reader #(.STABLE_CYCLES(SC), .MIN_PHASE(MINP), .MAX_PHASE(MAXP)) dut (
    .clk(clk), .rst(rst), .seg(seg), .code(code), .blinking(blinking),
    .illegal(illegal), .half_period(half_period), .upd(upd)
  );

  // Reference model: seg history window, acceptance and blink rules.
  logic [6:0] hist [$];
  int m_st, m_ref, m_acc, m_ph, m_onlen, m_half, m_blink;
  int e_code, e_ill, e_upd;

  function automatic int dec(input int p);
    for (int i = 0; i < 14; i++) if (int'(TBL[i]) == p) return i;
    return 15;
  endfunction

  function automatic bit inr(input int len);
    return (len >= MINP) && (len <= MAXP);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SC; i++) hist.push_back(7'h00);
    m_st = M_EMPTY; m_ref = 0; m_acc = 0; m_ph = 0; m_onlen = 0; m_half = 0;
    m_blink = 0; e_code = 10; e_ill = 0; e_upd = 0;
  endtask

  task automatic model_edge();
    bit acc_now;
    int p, len, oc, ob, oi;
    if (rst) begin
      model_reset();
    end else begin
      hist.push_back(seg);
      p = int'(hist[0]);
      acc_now = (p != m_acc);
      for (int i = 1; i < SC; i++) if (int'(hist[i]) != p) acc_now = 0;
      void'(hist.pop_front());
      len = m_ph;
      oc = e_code; ob = m_blink; oi = e_ill;
      if (acc_now) begin
        m_acc = p;
        if (m_st == M_EMPTY) begin
          if (p != 0) begin m_ref = p; m_st = M_STEADY; end
        end else if (m_st == M_STEADY) begin
          if (p == 0) begin m_onlen = len; m_st = M_GAP; end
          else m_ref = p;
        end else if (m_st == M_GAP) begin
          if (p == m_ref) begin
            if (inr(m_onlen) && inr(len)) begin m_st = M_BON; m_blink = 1; m_half = len; end
            else m_st = M_STEADY;
          end else begin m_ref = p; m_st = M_STEADY; end
        end else if (m_st == M_BON) begin
          if (p == 0) begin
            m_onlen = len;
            if (inr(len)) begin m_st = M_BOFF; m_half = len; end
            else begin m_st = M_GAP; m_blink = 0; end
          end else begin m_ref = p; m_st = M_STEADY; m_blink = 0; end
        end else begin
          if (p == m_ref && inr(len)) begin m_st = M_BON; m_half = len; end
          else if (p == m_ref) begin m_st = M_STEADY; m_blink = 0; end
          else begin m_ref = p; m_st = M_STEADY; m_blink = 0; end
        end
      end else if (len > MAXP) begin
        if (m_st == M_GAP) m_st = M_EMPTY;
        else if (m_st == M_BON) begin m_st = M_STEADY; m_blink = 0; end
        else if (m_st == M_BOFF) begin m_st = M_EMPTY; m_blink = 0; end
      end
      m_ph   = acc_now ? 1 : ((len + 1 > SAT) ? SAT : len + 1);
      e_code = (m_st == M_EMPTY) ? 10 : dec(m_ref);
      e_ill  = (m_st != M_EMPTY && dec(m_ref) == 15) ? 1 : 0;
      e_upd  = (e_code != oc || m_blink != ob || e_ill != oi) ? 1 : 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("code", 32'(code), e_code);
    chk("blinking", 32'(blinking), m_blink);
    chk("illegal", 32'(illegal), e_ill);
    chk("half_period", 32'(half_period), m_half);
    chk("upd", 32'(upd), e_upd);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seg = 7'h00;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, r, dur, pick;
    logic [6:0] pat, last, last_nb;
    rst = 1'b1;
    seg = 7'h00;
    model_reset();
    #1;
    do_reset();
    chk("reset_code", 32'(code), 32'd10);
    chk("reset_blink", 32'(blinking), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_half", 32'(half_period), 32'd0);
    chk("reset_upd", 32'(upd), 32'd0);

    // Steady 6D: update lands on the sixth edge after the change
    seg = 7'h6D;
    cnt = 0;
    repeat (5) begin tick(); cnt += int'(upd); end
    chk("6D_before_edge6", 32'(code), 32'd10);
    tick(); cnt += int'(upd);
    chk("6D_edge6_code", 32'(code), 32'd2);
    chk("6D_edge6_upd", 32'(upd), 32'd1);
    repeat (14) begin tick(); cnt += int'(upd); end
    chk("6D_upd_count", 32'(cnt), 32'd1);
    chk("6D_illegal", 32'(illegal), 32'd0);

    // Short glitch is ignored
    hold(7'h5B, 20);
    chk("5B_code", 32'(code), 32'd5);
    cnt = 0;
    seg = 7'h7F;
    repeat (3) begin tick(); cnt += int'(upd); end
    seg = 7'h5B;
    repeat (20) begin tick(); cnt += int'(upd); end
    chk("glitch_upd_count", 32'(cnt), 32'd0);
    chk("glitch_code", 32'(code), 32'd5);

    // Blink lock on 79/00 with 40-cycle phases, then long blank times out
    do_reset();
    hold(7'h79, 40); hold(7'h00, 40); hold(7'h79, 40);
    chk("blink_lock", 32'(blinking), 32'd1);
    chk("blink_code", 32'(code), 32'd3);
    chk("blink_half", 32'(half_period), 32'd40);
    hold(7'h00, 40); hold(7'h79, 40);
    chk("blink_code_hold", 32'(code), 32'd3);
    hold(7'h00, 150);
    chk("timeout_blink", 32'(blinking), 32'd0);
    chk("timeout_code", 32'(code), 32'd10);

    // Illegal pattern during a blink
    do_reset();
    hold(7'h79, 40); hold(7'h00, 40); hold(7'h79, 40); hold(7'h00, 40); hold(7'h79, 40);
    hold(7'h4A, 20);
    chk("4A_code", 32'(code), 32'd15);
    chk("4A_illegal", 32'(illegal), 32'd1);
    chk("4A_blink", 32'(blinking), 32'd0);

    // Reset while in BLINK_ON
    do_reset();
    hold(7'h79, 40); hold(7'h00, 40); hold(7'h79, 10);
    chk("pre_rst_blink", 32'(blinking), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_blink", 32'(blinking), 32'd0);
    chk("rst_code", 32'(code), 32'd10);
    chk("rst_half", 32'(half_period), 32'd0);
    hold(7'h79, 20);

    // Randomized patterns biased toward digit/blank alternation
    last = 7'h79;
    last_nb = 7'h79;
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4 && last != 7'h00) pat = 7'h00;
      else if (r < 7 && last == 7'h00) pat = last_nb;
      else begin
        pick = int'($urandom_range(0, 16));
        pat = (pick < 14) ? TBL[pick] : BAD[pick - 14];
      end
      r = int'($urandom_range(0, 9));
      if (r < 2) dur = int'($urandom_range(1, 5));
      else if (r < 9) dur = int'($urandom_range(6, 50));
      else dur = int'($urandom_range(90, 130));
      if (pat != 7'h00) last_nb = pat;
      last = pat;
      hold(pat, dur);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
